nx_fifo_unpacker: RTL and testbench
===================================

Name: nx_fifo_unpacker

Overview:
- Downstream consumer of the 128-bit show-ahead nx_fifo (depth 3).
- Pops one IN_WIDTH word whenever the FIFO is non-empty and its holding register is free or freeing.
- Emits the word as RATIO = IN_WIDTH/OUT_WIDTH narrower slices on a valid/ready interface.
- Sits between the FIFO and narrow-datapath stages. Output data is driven from a register, so FIFO rdata never feeds the sink combinationally.

Parameters:
- IN_WIDTH, 128, FIFO word width; must equal the FIFO WIDTH.
- OUT_WIDTH, 32, slice width; IN_WIDTH must be an integer multiple of it; RATIO must be >= 2.
- MSB_FIRST, 0, slice order: 0 = bits [OUT_WIDTH-1:0] first; 1 = top slice first.
- CNT_WIDTH, 16, width of the popped-word counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- clear  in  1  synchronous flush of the holding stage.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  IN_WIDTH  FIFO head word; valid when fifo_empty=0.
- fifo_ren  out  1  pop strobe to the FIFO (combinational).
- out_valid  out  1  slice valid.
- out_ready  in  1  sink ready.
- out_data  out  OUT_WIDTH  current slice.
- out_last  out  1  current slice is the final slice of its word.
- out_idx  out  clog2(RATIO)  index of the current slice in emission order.
- busy  out  1  holding register occupied (equals out_valid).
- pop_cnt  out  CNT_WIDTH  words popped since reset; wraps modulo 2^CNT_WIDTH.

Behaviour:
- State held in registers:
  - hold_q: IN_WIDTH.
  - hold_vld.
  - idx_q: clog2(RATIO).
  - pop_cnt_q.
- Reset (async, rst=1): hold_vld=0, idx_q=0, hold_q=0, pop_cnt=0. Therefore out_valid=0, out_last=0, out_idx=0, out_data=0, busy=0, and fifo_ren=0 while rst is high.
- Handshake signals:
  - accept = out_valid & out_ready.
  - drain = accept & (idx_q==RATIO-1).
- Pop rule: fifo_ren = !clear & !fifo_empty & (!hold_vld | drain). fifo_ren is never asserted while fifo_empty=1, so the FIFO cannot underflow.
- On fifo_ren: hold_q <= fifo_rdata, hold_vld <= 1, idx_q <= 0, pop_cnt++.
- Else on drain: hold_vld <= 0, idx_q <= 0.
- Else on accept: idx_q <= idx_q+1.
- No accept: all state holds. out_data and out_valid stay stable while out_valid=1 and out_ready=0 (AXI-style).
- Output mapping:
  - out_valid = hold_vld.
  - out_last = hold_vld & (idx_q==RATIO-1).
  - out_idx = idx_q.
  - MSB_FIRST=0: out_data = hold_q[idx_q*OUT_WIDTH +: OUT_WIDTH].
  - MSB_FIRST=1: out_data = hold_q[(RATIO-1-idx_q)*OUT_WIDTH +: OUT_WIDTH].
  - out_data = 0 when !hold_vld.
- Latency: when fifo_empty falls in cycle N with the stage idle, fifo_ren=1 in N and out_valid=1 in N+1.
- Throughput: with out_ready held high and the FIFO never empty, one slice per cycle with no bubble between words. The last slice of word k and the pop of word k+1 occur in the same cycle.
- Boundary conditions:
  - FIFO empty at drain: hold_vld drops; out_valid=0 the next cycle; the next pop occurs when fifo_empty falls.
  - clear=1: hold_vld <= 0, idx_q <= 0, fifo_ren=0 that cycle. Any accept in that cycle is discarded and pop_cnt is unchanged. A partially emitted word is dropped. clear has priority over accept, drain and pop.
  - rst asserted mid-word: state is lost immediately (async). The FIFO is reset by the same domain reset.
  - pop_cnt wraps from 2^CNT_WIDTH-1 to 0 with no flag.

Decomposition:
- Shared package nx_unpack_pkg:
  - localparam function for RATIO and index width.
  - typedef for the slice-index type.
  - Compile-time check: IN_WIDTH % OUT_WIDTH == 0 and RATIO >= 2.
- No sub-module needed. The slice mux is one indexed part-select.
- The bench instantiates nx_fifo (DEPTH=3, WIDTH=128) directly upstream.

Test Plan:
- Single word, MSB_FIRST=0: write 128'h44444444_33333333_22222222_11111111, out_ready=1 → fifo_ren one cycle. Slices 11111111, 22222222, 33333333, 44444444 on consecutive cycles, out_last on the 4th, out_idx 0..3, pop_cnt=1.
- Back-to-back: 3 words in the FIFO, out_ready=1 → 12 consecutive valid cycles with no bubble. fifo_ren pulses coincide with out_last, pop_cnt=3, FIFO empty at the end, no underflow flagged.
- Backpressure: out_ready=0 for 5 cycles on slice 2 → out_data/out_idx stable. No fifo_ren while the FIFO holds 2 more words. Emission resumes at idx 2 when out_ready rises.
- MSB_FIRST=1, same word as the single-word test → slices emitted 44444444, 33333333, 22222222, 11111111.
- clear after slice 1 accepted → out_valid=0 the next cycle and the word is not resumed. The next FIFO word pops the cycle after clear deasserts and starts at idx 0.
- Async rst pulse mid-word (between clock edges) → out_valid, busy and pop_cnt go to 0 before the next edge. fifo_ren=0 during reset.

Source files
------------

// File: rtl/nx_fifo_unpacker_pkg.sv
// Shared sizing helpers for the FIFO word unpacker: slice ratio, index width,
// and the parameter legality check used at elaboration.
package nx_unpack_pkg;

    function automatic int calc_ratio(input int in_w, input int out_w);
        return (out_w > 0) ? in_w / out_w : 0;
    endfunction

    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic bit widths_ok(input int in_w, input int out_w);
        return (out_w > 0) && (in_w % out_w == 0) && (in_w / out_w >= 2);
    endfunction

    localparam int DEF_IN_WIDTH  = 128;
    localparam int DEF_OUT_WIDTH = 32;
    localparam int DEF_RATIO     = calc_ratio(DEF_IN_WIDTH, DEF_OUT_WIDTH);
    localparam int DEF_IDX_W     = idx_width(DEF_RATIO);

    typedef logic [DEF_IDX_W-1:0] slice_idx_t;

endpackage

// File: rtl/nx_fifo_unpacker_if.sv
// FIFO read side plus narrow valid/ready slice stream of the unpacker.
// master = unpacker, slave = FIFO/sink side.
interface nx_fifo_unpacker_if #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 32
);
    localparam int IDX_W = nx_unpack_pkg::idx_width(nx_unpack_pkg::calc_ratio(IN_WIDTH, OUT_WIDTH));

    logic                 fifo_empty;
    logic [IN_WIDTH-1:0]  fifo_rdata;
    logic                 fifo_ren;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic [IDX_W-1:0]     out_idx;

    modport master (
        input  fifo_empty, fifo_rdata, out_ready,
        output fifo_ren, out_valid, out_data, out_last, out_idx
    );

    modport slave (
        output fifo_empty, fifo_rdata, out_ready,
        input  fifo_ren, out_valid, out_data, out_last, out_idx
    );

endinterface

// File: rtl/nx_fifo.sv
// Small show-ahead FIFO: rdata presents the head word whenever empty=0.
// overflow/underflow are sticky error flags cleared only by reset.
module nx_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] cnt;
    logic             do_wr, do_rd;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(DEPTH));
    assign do_wr = wen & ~full;
    assign do_rd = ren & ~empty;
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_wr) wptr <= (wptr == PTR_LAST) ? '0 : wptr + PTR_W'(1);
            if (do_rd) rptr <= (rptr == PTR_LAST) ? '0 : rptr + PTR_W'(1);
            cnt <= cnt + CNT_W'(do_wr) - CNT_W'(do_rd);
            if (wen & full)  overflow  <= 1'b1;
            if (ren & empty) underflow <= 1'b1;
        end
    end

endmodule

// File: rtl/nx_fifo_unpacker.sv
// Pops one wide word from a show-ahead FIFO into a holding register and emits
// it as RATIO registered slices on a valid/ready stream, no bubble between words.
module nx_fifo_unpacker
    import nx_unpack_pkg::*;
#(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 32,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    nx_fifo_unpacker_if.master   bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pop_cnt
);
    localparam int RATIO = calc_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int IDX_W = idx_width(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if (!widths_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_widths
        $error("nx_fifo_unpacker: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
    end

    logic [IN_WIDTH-1:0]  hold_q;
    logic                 hold_vld;
    logic [IDX_W-1:0]     idx_q;
    logic [CNT_WIDTH-1:0] pop_cnt_q;
    logic [IDX_W-1:0]     sel;
    logic                 accept, drain, pop;

    assign accept = hold_vld & bus.out_ready;
    assign drain  = accept & (idx_q == LAST_IDX);
    // rst gate keeps the pop strobe quiet while the FIFO is being reset too.
    assign pop    = ~rst & ~clear & ~bus.fifo_empty & (~hold_vld | drain);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            hold_vld  <= 1'b0;
            idx_q     <= '0;
            pop_cnt_q <= '0;
        end else if (clear) begin
            hold_vld <= 1'b0;
            idx_q    <= '0;
        end else if (pop) begin
            hold_q    <= bus.fifo_rdata;
            hold_vld  <= 1'b1;
            idx_q     <= '0;
            pop_cnt_q <= pop_cnt_q + CNT_WIDTH'(1);
        end else if (drain) begin
            hold_vld <= 1'b0;
            idx_q    <= '0;
        end else if (accept) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    assign sel = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;

    assign bus.fifo_ren  = pop;
    assign bus.out_valid = hold_vld;
    assign bus.out_last  = hold_vld & (idx_q == LAST_IDX);
    assign bus.out_idx   = idx_q;
    assign bus.out_data  = hold_vld ? hold_q[sel*OUT_WIDTH +: OUT_WIDTH] : '0;
    assign busy          = hold_vld;
    assign pop_cnt       = pop_cnt_q;

endmodule

// File: tb/tb_nx_fifo_unpacker.sv
// Directed bench: nx_fifo feeding the LSB-first unpacker, plus a bench-driven
// MSB-first instance.
module tb_nx_fifo_unpacker;
    localparam int IW = 128;
    localparam int OW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          clear2 = 1'b0;
    logic          wen = 1'b0;
    logic [IW-1:0] wdata = '0;
    logic          full, overflow, underflow;
    logic          busy, busy2;
    logic [CW-1:0] pop_cnt, pop_cnt2;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    nx_fifo_unpacker_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();
    nx_fifo_unpacker_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus2 ();

    nx_fifo #(.WIDTH(IW), .DEPTH(3)) u_fifo (
        .clk(clk), .rst(rst), .wen(wen), .wdata(wdata),
        .ren(bus.fifo_ren), .rdata(bus.fifo_rdata), .empty(bus.fifo_empty),
        .full(full), .overflow(overflow), .underflow(underflow)
    );

    nx_fifo_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1'b0), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .bus(bus), .busy(busy), .pop_cnt(pop_cnt)
    );

    nx_fifo_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1'b1), .CNT_WIDTH(CW)) u_msb (
        .clk(clk), .rst(rst), .clear(clear2), .bus(bus2), .busy(busy2), .pop_cnt(pop_cnt2)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    localparam logic [127:0] W1 = 128'h44444444_33333333_22222222_11111111;
    logic [31:0]  lsb1 [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    logic [31:0]  msb1 [4] = '{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    logic [127:0] w2 [3] = '{128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0,
                             128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0,
                             128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0};
    logic [31:0]  exp2 [12] = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3,
                                32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3,
                                32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3};

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int n, first, lastc;
        bus.out_ready   = 1'b0;
        bus2.out_ready  = 1'b0;
        bus2.fifo_empty = 1'b1;
        bus2.fifo_rdata = '0;

        // reset state, and no pop while rst is high even with data offered
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_last",  bus.out_last,  0);
        chk("rst_idx",   bus.out_idx,   0);
        chk("rst_data",  bus.out_data,  0);
        chk("rst_busy",  busy,          0);
        chk("rst_cnt",   pop_cnt,       0);
        bus2.fifo_empty = 1'b0;
        #1;
        chk("rst_ren", bus2.fifo_ren, 0);
        bus2.fifo_empty = 1'b1;
        @(negedge clk); rst = 1'b0;

        // single word, LSB first
        @(negedge clk); wen = 1'b1; wdata = W1; bus.out_ready = 1'b1; #1;
        chk("t1_ren_empty", bus.fifo_ren, 0);
        @(negedge clk); wen = 1'b0; #1;
        chk("t1_ren",     bus.fifo_ren,  1);
        chk("t1_vld_pre", bus.out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("t1_vld",  bus.out_valid, 1);
            chk("t1_data", bus.out_data,  lsb1[i]);
            chk("t1_idx",  bus.out_idx,   i);
            chk("t1_last", bus.out_last,  i == 3);
            chk("t1_ren0", bus.fifo_ren,  0);
        end
        @(negedge clk); #1;
        chk("t1_vld_end",  bus.out_valid, 0);
        chk("t1_busy_end", busy,          0);
        chk("t1_data_end", bus.out_data,  0);
        chk("t1_cnt",      pop_cnt,       1);

        // same word, MSB first, FIFO side driven by the bench
        @(negedge clk); bus2.fifo_empty = 1'b0; bus2.fifo_rdata = W1; bus2.out_ready = 1'b1; #1;
        chk("msb_ren", bus2.fifo_ren, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) bus2.fifo_empty = 1'b1;
            #1;
            chk("msb_data", bus2.out_data, msb1[i]);
            chk("msb_idx",  bus2.out_idx,  i);
            chk("msb_last", bus2.out_last, i == 3);
        end
        @(negedge clk); #1;
        chk("msb_vld_end", bus2.out_valid, 0);
        chk("msb_cnt",     pop_cnt2,       1);

        // back-to-back: three words, 12 slices with no bubble
        n = 0; first = -1; lastc = -1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            wen = (c < 3);
            if (c < 3) wdata = w2[c];
            #1;
            if (bus.out_valid === 1'b1) begin
                if (n < 12) chk("b2b_data", bus.out_data, exp2[n]);
                chk("b2b_idx", bus.out_idx, n % 4);
                chk("b2b_ren", bus.fifo_ren, (n % 4 == 3) && (n < 8));
                if (first < 0) first = c;
                lastc = c;
                n++;
            end
        end
        chk("b2b_slices", n, 12);
        chk("b2b_span",   lastc - first + 1, 12);
        chk("b2b_cnt",    pop_cnt, 4);
        chk("b2b_empty",  bus.fifo_empty, 1);
        chk("b2b_unflow", underflow, 0);
        chk("b2b_ovflow", overflow, 0);

        // backpressure on slice 2 with two more words queued
        bus.out_ready = 1'b0;
        @(negedge clk); wen = 1'b1; wdata = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0; #1;
        @(negedge clk); wdata = 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0; #1;
        chk("bp_pop", bus.fifo_ren, 1);
        @(negedge clk); wdata = 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0; #1;
        chk("bp_idx0", bus.out_idx, 0);
        @(negedge clk); wen = 1'b0; bus.out_ready = 1'b1; #1;
        @(negedge clk); #1;
        chk("bp_idx1", bus.out_idx, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); bus.out_ready = 1'b0; #1;
            chk("bp_hold_vld",  bus.out_valid, 1);
            chk("bp_hold_idx",  bus.out_idx,   2);
            chk("bp_hold_data", bus.out_data,  32'hD2D2D2D2);
            chk("bp_hold_ren",  bus.fifo_ren,  0);
        end
        @(negedge clk); bus.out_ready = 1'b1; #1;
        chk("bp_resume_idx",  bus.out_idx,  2);
        chk("bp_resume_data", bus.out_data, 32'hD2D2D2D2);
        @(negedge clk); #1;
        chk("bp_last_data", bus.out_data, 32'hD3D3D3D3);
        chk("bp_last",      bus.out_last, 1);
        chk("bp_last_ren",  bus.fifo_ren, 1);
        repeat (9) @(negedge clk);
        #1;
        chk("bp_vld_end", bus.out_valid, 0);
        chk("bp_cnt",     pop_cnt, 7);
        chk("bp_empty",   bus.fifo_empty, 1);

        // clear mid-word drops it; next word pops once clear falls
        @(negedge clk); wen = 1'b1; wdata = 128'h63636363_62626262_61616161_60606060; #1;
        @(negedge clk); wdata = 128'h73737373_72727272_71717171_70707070; #1;
        chk("clr_pop", bus.fifo_ren, 1);
        @(negedge clk); wen = 1'b0; #1;
        chk("clr_g0", bus.out_data, 32'h60606060);
        @(negedge clk); #1;
        chk("clr_g1", bus.out_idx, 1);
        @(negedge clk); clear = 1'b1; #1;
        chk("clr_ren_blk", bus.fifo_ren, 0);
        chk("clr_idx2",    bus.out_idx,  2);
        @(negedge clk); clear = 1'b0; #1;
        chk("clr_vld",   bus.out_valid, 0);
        chk("clr_ren",   bus.fifo_ren,  1);
        chk("clr_cnt",   pop_cnt,       8);
        @(negedge clk); #1;
        chk("clr_h_vld",  bus.out_valid, 1);
        chk("clr_h_idx",  bus.out_idx,   0);
        chk("clr_h_data", bus.out_data,  32'h70707070);
        chk("clr_h_cnt",  pop_cnt,       9);
        repeat (4) @(negedge clk);
        #1;
        chk("clr_end_vld", bus.out_valid, 0);

        // async reset between edges, mid-word
        @(negedge clk); wen = 1'b1; wdata = 128'h93939393_92929292_91919191_90909090; #1;
        @(negedge clk); wdata = 128'h83838383_82828282_81818181_80808080; #1;
        @(negedge clk); wen = 1'b0; #1;
        @(negedge clk); #1;
        chk("ar_idx1", bus.out_idx, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_vld",  bus.out_valid, 0);
        chk("ar_busy", busy,          0);
        chk("ar_cnt",  pop_cnt,       0);
        chk("ar_ren",  bus.fifo_ren,  0);
        chk("ar_idx",  bus.out_idx,   0);
        chk("ar_data", bus.out_data,  0);
        @(negedge clk); rst = 1'b0; #1;
        chk("ar_post_vld",   bus.out_valid,  0);
        chk("ar_post_empty", bus.fifo_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
